fifo_skew_ctrl: RTL and testbench

Parametrised read-enable sequencer for the systolic array's input FIFO bank. On a start pulse it drives a diagonal (skewed) pattern of per-channel enables: channel k is enabled for `len` consecutive cycles, delayed k cycles from channel 0. It extends the fixed 4-channel controller with:

- a configurable channel count;
- a runtime burst length;
- a selectable skew direction;
- a stall input;
- busy/done status for the top-level sequencer.

---
 rtl/fifo_skew_ctrl.sv | 59 +++++
 tb/tb_fifo_skew_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_skew_ctrl.sv
// fifo_skew_ctrl: skewed per-channel pop-enable sequencer for the systolic input FIFO bank
module fifo_skew_ctrl #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              reverse,
  input  logic              stall,
  output logic [NUM_CH-1:0] fifo_en,
  output logic              busy,
  output logic              done
);
  localparam int CW = LEN_W + $clog2(NUM_CH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] t, t_nxt, last;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic rev_q, rev_nxt, go;
  logic [NUM_CH-1:0] mask, mask_nxt;
  // state, counter, latched config and registered mask
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      t     <= '0;
      len_q <= '0;
      rev_q <= 1'b0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      len_q <= len_nxt;
      rev_q <= rev_nxt;
      mask  <= mask_nxt;
    end
  // next state, next counter and the mask for the counter value about to be loaded
  always_comb begin
    go        = state == IDLE && start;
    len_nxt   = go ? len : len_q;
    rev_nxt   = go ? reverse : rev_q;
    last      = CW'(len_q) + CW'(NUM_CH - 2);
    state_nxt = state == IDLE ? (start ? (len == '0 ? DONE : RUN) : IDLE) :
                state == RUN  ? ((!stall && t == last) ? DONE : RUN) : IDLE;
    t_nxt     = go ? '0 : (state == RUN && !stall) ? t + 1'b1 : t;
    mask_nxt  = '0;
    for (int k = 0; k < NUM_CH; k++)
      mask_nxt[k] = state_nxt == RUN &&
                    t_nxt >= CW'(rev_nxt ? NUM_CH - 1 - k : k) &&
                    t_nxt <  CW'(rev_nxt ? NUM_CH - 1 - k : k) + CW'(len_nxt);
  end
  // status decode and combinational stall gating of the enables
  always_comb begin
    busy    = state == RUN;
    done    = state == DONE;
    fifo_en = mask & {NUM_CH{~stall}};
  end
endmodule

// File: tb/tb_fifo_skew_ctrl.sv
// tb_fifo_skew_ctrl: directed checks of the skewed enable sequencer
module tb_fifo_skew_ctrl;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, reverse = 1'b0, stall = 1'b0;
  logic [7:0] len = '0;
  logic [3:0] fifo_en;
  logic busy, done;
  int total = 0, bad = 0;

  fifo_skew_ctrl #(.NUM_CH(4), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .reverse(reverse),
    .stall(stall), .fifo_en(fifo_en), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic kick(input logic [7:0] l, input logic r);
    @(negedge clk);
    start = 1'b1; len = l; reverse = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (fifo_en !== 4'h0) begin bad++; $display("FAIL reset_en got=%h exp=0", fifo_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({fifo_en, busy, done} !== 6'b0) begin
        bad++; $display("FAIL idle_quiet cyc=%0d got=%b exp=000000", i, {fifo_en, busy, done});
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] e [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    kick(8'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (fifo_en !== e[i] || busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL basic cyc=%0d got en=%h busy=%b done=%b exp en=%h busy=1 done=0", i, fifo_en, busy, done, e[i]);
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || fifo_en !== 4'h0) begin
      bad++; $display("FAIL basic_done got en=%h busy=%b done=%b exp en=0 busy=0 done=1", fifo_en, busy, done);
    end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_reverse();
    logic [3:0] e [5] = '{4'h8, 4'hC, 4'h6, 4'h3, 4'h1};
    kick(8'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (fifo_en !== e[i] || busy !== 1'b1) begin
        bad++; $display("FAIL reverse cyc=%0d got en=%h busy=%b exp en=%h busy=1", i, fifo_en, busy, e[i]);
      end
      @(negedge clk);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL reverse_done got=%b exp=1", done); end
  endtask

  task automatic test_stall();
    logic [3:0] e [8] = '{4'h1, 4'h3, 4'h0, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8};
    kick(8'd3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (fifo_en !== e[i] || busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL stall cyc=%0d got en=%h busy=%b done=%b exp en=%h busy=1 done=0", i, fifo_en, busy, done, e[i]);
      end
      stall = (i == 1 || i == 2);
      @(negedge clk);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", done); end
    @(negedge clk);
  endtask

  task automatic test_len0();
    kick(8'd0, 1'b0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || fifo_en !== 4'h0) begin
      bad++; $display("FAIL len0 got en=%h busy=%b done=%b exp en=0 busy=0 done=1", fifo_en, busy, done);
    end
    @(negedge clk);
    total++;
    if ({fifo_en, busy, done} !== 6'b0) begin
      bad++; $display("FAIL len0_after got=%b exp=000000", {fifo_en, busy, done});
    end
  endtask

  task automatic test_restart_ignored();
    logic [3:0] e [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    kick(8'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (fifo_en !== e[i]) begin
        bad++; $display("FAIL restart cyc=%0d got=%h exp=%h", i, fifo_en, e[i]);
      end
      start = (i == 1); len = (i == 1) ? 8'd5 : 8'd3; reverse = (i == 1);
      @(negedge clk);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done got=%b exp=1", done); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_not_queued busy=%b exp=0", busy); end
  endtask

  task automatic test_long();
    int busy_cnt = 0, en_cnt = 0;
    logic seen = 1'b0;
    kick(8'd255, 1'b0);
    for (int i = 0; i < 400 && !seen; i++) begin
      if (i == 100) begin
        total++; if (fifo_en !== 4'hF) begin bad++; $display("FAIL long_mid got=%h exp=f", fifo_en); end
      end
      busy_cnt += busy;
      en_cnt += (fifo_en != 4'h0);
      seen = done;
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL long_timeout done=0 exp=1"); end
    total++; if (busy_cnt != 258) begin bad++; $display("FAIL long_busy got=%0d exp=258", busy_cnt); end
    total++; if (en_cnt != 258) begin bad++; $display("FAIL long_en got=%0d exp=258", en_cnt); end
  endtask

  task automatic test_async_reset();
    logic [3:0] e [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    kick(8'd3, 1'b0);
    repeat (2) @(negedge clk);
    total++; if (fifo_en !== 4'h7) begin bad++; $display("FAIL arst_pre got=%h exp=7", fifo_en); end
    #1 reset = 1'b0;
    #1;
    total++;
    if (fifo_en !== 4'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL arst_now got en=%h busy=%b exp en=0 busy=0", fifo_en, busy);
    end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b exp=0", done); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_no_resume busy=%b exp=0", busy); end
    kick(8'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (fifo_en !== e[i]) begin
        bad++; $display("FAIL arst_rerun cyc=%0d got=%h exp=%h", i, fifo_en, e[i]);
      end
      @(negedge clk);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL arst_rerun_done got=%b exp=1", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse();
    test_stall();
    test_len0();
    test_restart_ignored();
    test_long();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
